// File: rtl/beat_period_meter.sv
// Measures the clk_in-cycle period between successive rising edges of an asynchronous input,
// rejecting edges that come too early and flagging loss of signal after MAX_PERIOD cycles.
module beat_period_meter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MIN_PERIOD = 16_250_000,
  parameter int unsigned MAX_PERIOD = 195_000_000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  output logic             edge_rejected,
  output logic             timeout,
  output logic             locked,
  output logic [15:0]      beat_count
);

  localparam logic [WIDTH-1:0] MinCnt = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_PERIOD);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             rej_q, rej_d;
  logic             to_q, to_d;
  logic             locked_q, locked_d;
  logic [15:0]      beat_q, beat_d;
  logic             rise;

  // sync_q[0..1] is the two-flop synchronizer, sync_q[2] the history flop for edge detect
  assign sync_d = {sync_q[1:0], sig_in};
  assign rise   = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    locked_d = locked_q;
    beat_d   = beat_q;
    valid_d  = 1'b0;
    rej_d    = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d    = '0;
        locked_d = 1'b0;
        if (rise) begin
          state_d = StMeasure;
          cnt_d   = WIDTH'(1);
        end
      end
      StMeasure: begin
        // A rise at exactly MAX_PERIOD wins over the timeout
        if (rise && (cnt_q >= MinCnt)) begin
          period_d = cnt_q;
          cnt_d    = WIDTH'(1);
          locked_d = 1'b1;
          beat_d   = beat_q + 16'd1;
          valid_d  = 1'b1;
        end else if (rise) begin
          rej_d = 1'b1;
          cnt_d = cnt_q + WIDTH'(1);
        end else if (cnt_q == MaxCnt) begin
          to_d     = 1'b1;
          locked_d = 1'b0;
          state_d  = StIdle;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      sync_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      rej_q    <= 1'b0;
      to_q     <= 1'b0;
      locked_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      rej_q    <= rej_d;
      to_q     <= to_d;
      locked_q <= locked_d;
      beat_q   <= beat_d;
    end
  end

  assign period_out    = period_q;
  assign period_valid  = valid_q;
  assign edge_rejected = rej_q;
  assign timeout       = to_q;
  assign locked        = locked_q;
  assign beat_count    = beat_q;

endmodule

// File: tb/tb_beat_period_meter.sv
// Directed bench for beat_period_meter with MIN_PERIOD=10, MAX_PERIOD=100, WIDTH=16.
module tb_beat_period_meter;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic        sig_in = 1'b0;
  logic [15:0] period_out;
  logic        period_valid;
  logic        edge_rejected;
  logic        timeout;
  logic        locked;
  logic [15:0] beat_count;

  beat_period_meter #(
    .WIDTH     (16),
    .MIN_PERIOD(10),
    .MAX_PERIOD(100)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .sig_in       (sig_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .edge_rejected(edge_rejected),
    .timeout      (timeout),
    .locked       (locked),
    .beat_count   (beat_count)
  );

  always #5 clk_in = ~clk_in;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_valid = 0;
  int          n_rej = 0;
  int          n_to = 0;
  int          consec_err = 0;
  int          excl_err = 0;
  int          cyc = 0;
  int          t_valid = 0;
  int          t_to = 0;
  logic [15:0] last_period = '0;
  logic        prev_any = 1'b0;

  // Strobe observer on the falling edge, away from the active edge
  always @(negedge clk_in) begin
    int  nstrobe;
    logic any;
    cyc++;
    nstrobe = int'(period_valid) + int'(edge_rejected) + int'(timeout);
    any     = (nstrobe != 0);
    if (nstrobe > 1) excl_err++;
    if (any && prev_any) consec_err++;
    prev_any = any;
    if (period_valid) begin
      n_valid++;
      last_period = period_out;
      t_valid = cyc;
    end
    if (edge_rejected) n_rej++;
    if (timeout) begin
      n_to++;
      t_to = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Rising edge now, next rising edge n cycles later
  task automatic beat(input int n);
    sig_in = 1'b1;
    repeat (n / 2) tick();
    sig_in = 1'b0;
    repeat (n - n / 2) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_period", 32'(period_out), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_beats", 32'(beat_count), 0);
    chk("rst_strobes", 32'({period_valid, edge_rejected, timeout}), 0);
    reset = 1'b1;
    repeat (3) tick();

    // 1: 40-cycle square wave, six edges
    beat(40);
    chk("t1_first_no_valid", 32'(n_valid), 0);
    chk("t1_first_unlocked", 32'(locked), 0);
    beat(40);
    chk("t1_second_valid", 32'(n_valid), 1);
    chk("t1_second_locked", 32'(locked), 1);
    repeat (4) beat(40);
    chk("t1_valid_count", 32'(n_valid), 5);
    chk("t1_period", 32'(period_out), 40);
    chk("t1_last_period", 32'(last_period), 40);
    chk("t1_beats", 32'(beat_count), 5);

    // 2: glitch 5 cycles after an accepted edge
    beat(5);
    chk("t2_accept", 32'(n_valid), 6);
    beat(35);
    chk("t2_glitch_rej", 32'(n_rej), 1);
    chk("t2_glitch_no_valid", 32'(n_valid), 6);
    chk("t2_glitch_beats", 32'(beat_count), 6);
    beat(40);
    chk("t2_after_glitch_valid", 32'(n_valid), 7);
    chk("t2_after_glitch_period", 32'(last_period), 40);
    chk("t2_beats", 32'(beat_count), 7);

    // 3: boundaries 9 (reject), 10 and 100 (accept)
    beat(9);
    beat(31);
    chk("t3_9_rejected", 32'(n_rej), 2);
    chk("t3_9_no_valid", 32'(n_valid), 8);
    beat(10);
    beat(100);
    chk("t3_10_valid", 32'(n_valid), 10);
    chk("t3_10_period", 32'(period_out), 10);
    beat(40);
    chk("t3_100_valid", 32'(n_valid), 11);
    chk("t3_100_period", 32'(last_period), 100);
    chk("t3_100_no_timeout", 32'(n_to), 0);

    // 4: lock at 40 then silence
    beat(150);
    chk("t4_timeout_count", 32'(n_to), 1);
    chk("t4_timeout_spacing", 32'(t_to - t_valid), 100);
    chk("t4_unlocked", 32'(locked), 0);
    chk("t4_period_held", 32'(period_out), 40);
    chk("t4_beats_held", 32'(beat_count), 12);
    beat(50);
    chk("t4_rearm_no_valid", 32'(n_valid), 12);
    chk("t4_rearm_unlocked", 32'(locked), 0);
    beat(40);
    chk("t4_relock_period", 32'(last_period), 50);
    chk("t4_relock_locked", 32'(locked), 1);
    chk("t4_relock_beats", 32'(beat_count), 13);

    // 5: asynchronous reset mid-measurement
    beat(20);
    chk("t5_pre_reset_valid", 32'(n_valid), 14);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_async_period", 32'(period_out), 0);
    chk("t5_async_locked", 32'(locked), 0);
    chk("t5_async_beats", 32'(beat_count), 0);
    chk("t5_async_strobes", 32'({period_valid, edge_rejected, timeout}), 0);
    repeat (2) tick();
    reset = 1'b1;
    beat(30);
    chk("t5_arm_no_valid", 32'(n_valid), 14);
    chk("t5_arm_unlocked", 32'(locked), 0);
    beat(40);
    chk("t5_period", 32'(last_period), 30);
    chk("t5_beats", 32'(beat_count), 1);
    chk("t5_locked", 32'(locked), 1);

    // 6: input stuck high
    sig_in = 1'b1;
    repeat (300) tick();
    sig_in = 1'b0;
    repeat (5) tick();
    chk("t6_valid_count", 32'(n_valid), 16);
    chk("t6_beats", 32'(beat_count), 2);
    chk("t6_timeout_count", 32'(n_to), 2);
    chk("t6_unlocked", 32'(locked), 0);
    chk("t6_rej_total", 32'(n_rej), 2);

    chk("strobe_exclusive", 32'(excl_err), 0);
    chk("strobe_single_cycle", 32'(consec_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/beat_period_meter.md
Name: beat_period_meter

Overview:
- Measures the period, in clk_in cycles, between successive rising edges of an asynchronous pulse input (heartbeat detector output or any divided clock).
- Inverse of our clock division path: it recovers the cycle count that a divider would need to reproduce the observed signal.
- Feeds BPM computation and display logic with a registered period word and a one-cycle valid strobe.
- Rejects edges that arrive too early (glitch or refractory window) and declares signal loss when edges stop arriving.

Parameters:
WIDTH, 32, width of the period counter and period_out
MIN_PERIOD, 16_250_000, minimum accepted period in cycles (0.25 s at 65 MHz, 240 bpm)
MAX_PERIOD, 195_000_000, maximum accepted period in cycles (3 s at 65 MHz, 20 bpm); constraint 2 <= MIN_PERIOD <= MAX_PERIOD < 2^WIDTH

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion
sig_in  input  1  asynchronous pulse or clock to measure
period_out  output  WIDTH  last accepted period in clk_in cycles
period_valid  output  1  one-cycle strobe when period_out updates
edge_rejected  output  1  one-cycle strobe when an edge arrives before MIN_PERIOD
timeout  output  1  one-cycle strobe when MAX_PERIOD elapses with no edge
locked  output  1  high once at least one valid period has been measured since the last reset or timeout
beat_count  output  16  number of accepted periods, wraps 0xFFFF -> 0

Behaviour:
- Reset (reset == 0, async): all outputs 0, counter 0, synchronizer flops 0, state IDLE.
- Input conditioning: sig_in passes through a 2-flop synchronizer plus a third history flop. rise = s2 & ~s3. The fixed 3-cycle latency cancels in period measurement.
- An input held constant high or low produces no rise events.
- State IDLE: counter held 0; locked = 0.
  - On rise: go to MEASURE, counter <= 1, no strobes.
- State MEASURE: counter counts cycles since the last accepted edge. If accepted rises occur at cycles t0 and t1, the counter equals t1 - t0 in cycle t1.
  - rise and counter >= MIN_PERIOD (counter <= MAX_PERIOD is implied): accept.
    - period_out <= counter; counter <= 1; locked <= 1; beat_count <= beat_count + 1.
    - period_valid high for exactly the next cycle.
  - rise and counter < MIN_PERIOD: reject. edge_rejected high for the next cycle; counter keeps incrementing; period_out, locked and beat_count unchanged.
  - no rise and counter == MAX_PERIOD: timeout high for the next cycle; locked <= 0; state <= IDLE; counter <= 0; period_out and beat_count hold their values.
  - otherwise: counter <= counter + 1.
- Boundaries:
  - A rise at exactly counter == MIN_PERIOD is accepted.
  - A rise at exactly counter == MAX_PERIOD is accepted and takes precedence over timeout.
  - The counter never exceeds MAX_PERIOD, so there is no wrap.
- Strobes are registered, mutually exclusive and never asserted two cycles in a row from one event.
- Reset mid-measurement: the partial count is discarded. After release, the first rise only arms MEASURE and produces no period_valid.
- Arithmetic is unsigned. The comparisons use the full WIDTH-bit counter.

Test Plan (bench overrides MIN_PERIOD=10, MAX_PERIOD=100, WIDTH=16):
1. Square wave with a 40-cycle period, 6 edges -> first edge gives no strobe; edges 2-6 each give period_valid with period_out=40; locked=1 after edge 2; beat_count=5.
2. Accepted edge, then glitch rise 5 cycles later, then next rise 40 cycles after the accepted edge -> edge_rejected pulse, no period_valid for the glitch; then period_out=40, beat_count+1.
3. Rises spaced 9, 10 and 100 cycles after an accepted edge (each test run separately) -> 9 rejected; 10 accepted with period_out=10; 100 accepted with period_out=100 and no timeout.
4. Lock at 40, then no edges -> timeout pulse exactly 100 cycles after the last accepted rise; locked=0; period_out stays 40. The next rise gives no valid; the following rise 50 cycles later gives period_out=50 and locked=1.
5. reset driven low mid-measurement, asynchronously between clock edges -> all outputs 0 before the next clk_in edge. After release, the first rise gives no strobe and the second gives the correct period.
6. sig_in held high for 300 cycles after a lock -> no extra rise; one timeout pulse; beat_count unchanged.
